sram_req_adapter: RTL and testbench

SRAM_REQ_ADAPTER -- requirements
Module: sram_req_adapter

---
 rtl/sram_req_adapter.sv | 130 +++++++++++++
 tb/tb_sram_req_adapter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_adapter.sv
// Request/response adapter in front of a single-port SRAM with 1-cycle read latency.
// Optionally zero-fills the SRAM after reset, then forwards requests and returns read data in order.
module sram_req_adapter #(
    parameter int DATA_WIDTH = 64,
    parameter int BYTE_WIDTH = 8,
    parameter int NUM_WORDS  = 1024,
    parameter int INIT_EN    = 1,
    localparam int BE_W      = (DATA_WIDTH + BYTE_WIDTH - 1) / BYTE_WIDTH,
    localparam int AW        = $clog2(NUM_WORDS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic                  init_done_o,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [AW-1:0]         req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [BE_W-1:0]       req_be_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  sram_req_o,
    output logic                  sram_we_o,
    output logic [AW-1:0]         sram_addr_o,
    output logic [DATA_WIDTH-1:0] sram_wdata_o,
    output logic [BE_W-1:0]       sram_be_o,
    input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    localparam state_t RESET_STATE = (INIT_EN != 0) ? ST_INIT : ST_RUN;

    state_t                state_reg, state_next;
    logic [AW-1:0]         init_cnt_reg, init_cnt_next;
    logic                  inflight_reg, inflight_next;
    logic [DATA_WIDTH-1:0] fifo_mem [2];
    logic                  wr_ptr_reg, rd_ptr_reg;
    logic [1:0]            count_reg;
    logic [2:0]            occupancy;
    logic                  accept, push, pop;

    assign init_done_o = (state_reg == ST_RUN);

    // Outputs are gated by rst_i so they drop immediately, before any clock edge.
    always_comb begin
        occupancy   = {1'b0, count_reg} + {2'b00, inflight_reg};
        req_ready_o = !rst_i && (state_reg == ST_RUN) && (occupancy < 3'd2);
        accept      = req_valid_i && req_ready_o;

        rsp_valid_o = !rst_i && (state_reg == ST_RUN) && ((count_reg != 2'd0) || inflight_reg);
        rsp_rdata_o = '0;
        if (rsp_valid_o) begin
            rsp_rdata_o = (count_reg != 2'd0) ? fifo_mem[rd_ptr_reg] : sram_rdata_i;
        end
        pop  = rsp_valid_o && rsp_ready_i && (count_reg != 2'd0);
        // Returning data is stored unless it bypasses straight to a ready consumer.
        push = inflight_reg && !((count_reg == 2'd0) && rsp_ready_i);
    end

    always_comb begin
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_be_o    = '0;
        state_next    = state_reg;
        init_cnt_next = init_cnt_reg;
        inflight_next = 1'b0;

        if (!rst_i) begin
            if (state_reg == ST_INIT) begin
                sram_req_o  = 1'b1;
                sram_we_o   = 1'b1;
                sram_addr_o = init_cnt_reg;
                sram_be_o   = '1;
                if (init_cnt_reg == AW'(NUM_WORDS - 1)) begin
                    state_next = ST_RUN;
                end else begin
                    init_cnt_next = init_cnt_reg + 1'b1;
                end
            end else if (accept) begin
                sram_req_o    = 1'b1;
                sram_we_o     = req_we_i;
                sram_addr_o   = req_addr_i;
                sram_wdata_o  = req_wdata_i;
                sram_be_o     = req_be_i;
                inflight_next = !req_we_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg    <= RESET_STATE;
            init_cnt_reg <= '0;
            inflight_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            init_cnt_reg <= init_cnt_next;
            inflight_reg <= inflight_next;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 2; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr_reg] <= sram_rdata_i;
                wr_ptr_reg           <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_req_adapter.sv
// Directed bench for sram_req_adapter: init sweep, write/read, backpressure, streaming, resets, INIT_EN=0.
module tb_sram_req_adapter;

    localparam logic [63:0] D0_RDATA = 64'h0123_4567_89AB_CDEF;

    logic        clk;
    logic        rst;
    logic        init_done, req_valid, req_ready, req_we, rsp_valid, rsp_ready;
    logic [3:0]  req_addr, sram_addr;
    logic [63:0] req_wdata, rsp_rdata, sram_wdata, sram_rdata;
    logic [7:0]  req_be, sram_be;
    logic        sram_req, sram_we;

    logic        init_done0, req_valid0, req_ready0, rsp_valid0;
    logic [3:0]  req_addr0, sram_addr0;
    logic [63:0] rsp_rdata0, sram_wdata0, sram_rdata0;
    logic [7:0]  sram_be0;
    logic        sram_req0, sram_we0;

    logic [63:0] sram_mem [16];
    logic [63:0] exp_mem  [16];
    int          wr_total, wr0_total, wr_start;
    int          checks, errors;

    sram_req_adapter #(.DATA_WIDTH(64), .BYTE_WIDTH(8), .NUM_WORDS(16), .INIT_EN(1)) dut (
        .clk_i(clk), .rst_i(rst), .init_done_o(init_done),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
        .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_rdata_i(sram_rdata)
    );

    sram_req_adapter #(.DATA_WIDTH(64), .BYTE_WIDTH(8), .NUM_WORDS(16), .INIT_EN(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .init_done_o(init_done0),
        .req_valid_i(req_valid0), .req_ready_o(req_ready0), .req_we_i(1'b0),
        .req_addr_i(req_addr0), .req_wdata_i(64'h0), .req_be_i(8'h00),
        .rsp_valid_o(rsp_valid0), .rsp_ready_i(1'b1), .rsp_rdata_o(rsp_rdata0),
        .sram_req_o(sram_req0), .sram_we_o(sram_we0), .sram_addr_o(sram_addr0),
        .sram_wdata_o(sram_wdata0), .sram_be_o(sram_be0), .sram_rdata_i(sram_rdata0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Byte-enabled SRAM model with one-cycle registered read.
    always @(posedge clk) begin
        if (sram_req) begin
            if (sram_we) begin
                for (int b = 0; b < 8; b++) begin
                    if (sram_be[b]) sram_mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
                end
            end else begin
                sram_rdata <= sram_mem[sram_addr];
            end
        end
    end

    always @(posedge clk) begin
        if (sram_req && sram_we) wr_total++;
        if (sram_req0 && sram_we0) wr0_total++;
        if (!rst && init_done && sram_req)
            $display("[%0t] req  %s addr=%0d data=%h be=%h", $time, sram_we ? "WR" : "RD",
                     sram_addr, sram_wdata, sram_be);
        if (!rst && rsp_valid && rsp_ready)
            $display("[%0t] rsp  data=%h", $time, rsp_rdata);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [3:0] a,
                         input logic [63:0] d, input logic [7:0] be);
        req_valid = v; req_we = we; req_addr = a; req_wdata = d; req_be = be;
        #1;
    endtask

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                          input logic [7:0] be);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    // Walks the init sweep; returns without advancing when address stop_at is on the bus.
    task automatic run_init(input int stop_at, input bit with_dut0);
        for (int i = 0; i < 16; i++) begin
            if (with_dut0 && i == 0) begin
                check("d0_init_done", init_done0, 1);
                check("d0_ready", req_ready0, 1);
                check("d0_sram_req", sram_req0, 1);
                check("d0_sram_addr", sram_addr0, 3);
            end
            if (with_dut0 && i == 1) begin
                req_valid0 = 1'b0;
                #1;
                check("d0_rsp_valid", rsp_valid0, 1);
                check("d0_rsp_rdata", rsp_rdata0, D0_RDATA);
            end
            check("init_req", sram_req, 1);
            check("init_we", sram_we, 1);
            check("init_addr", sram_addr, 64'(i));
            check("init_wdata", sram_wdata, 0);
            check("init_be", sram_be, 8'hFF);
            check("init_ready", req_ready, 0);
            check("init_done_lo", init_done, 0);
            check("init_rsp_valid", rsp_valid, 0);
            if (i == stop_at) return;
            tick();
        end
        check("init_done_hi", init_done, 1);
        for (int a = 0; a < 16; a++) exp_mem[a] = '0;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [63:0] d, input logic [7:0] be);
        drive(1, 1, a, d, be);
        check("wr_ready", req_ready, 1);
        check("wr_sram_req", sram_req, 1);
        check("wr_sram_we", sram_we, 1);
        check("wr_sram_addr", sram_addr, 64'(a));
        check("wr_sram_wdata", sram_wdata, d);
        check("wr_sram_be", sram_be, be);
        exp_mem[a] = merge(exp_mem[a], d, be);
        tick();
        drive(0, 0, 0, 0, 0);
        check("wr_no_rsp", rsp_valid, 0);
    endtask

    task automatic do_read(input logic [3:0] a);
        drive(1, 0, a, 0, 0);
        check("rd_ready", req_ready, 1);
        check("rd_sram_req", sram_req, 1);
        check("rd_sram_we", sram_we, 0);
        check("rd_sram_addr", sram_addr, 64'(a));
        tick();
        drive(0, 0, 0, 0, 0);
        check("rd_rsp_valid", rsp_valid, 1);
        check("rd_rsp_rdata", rsp_rdata, exp_mem[a]);
    endtask

    initial begin
        checks = 0; errors = 0; wr_total = 0; wr0_total = 0;
        rst = 1'b1; rsp_ready = 1'b1;
        req_valid0 = 1'b1; req_addr0 = 4'd3; sram_rdata0 = D0_RDATA;
        drive(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_sram_req", sram_req, 0);
        check("rst_sram_addr", sram_addr, 0);
        check("rst_sram_be", sram_be, 0);
        check("rst_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_init_done", init_done, 0);
        check("rst_d0_init_done", init_done0, 1);
        check("rst_d0_ready", req_ready0, 0);
        check("rst_d0_sram_req", sram_req0, 0);

        wr_start = wr_total;
        rst = 1'b0;
        #1;
        run_init(16, 1);
        check("post_init_ready", req_ready, 1);
        check("post_init_sram_req", sram_req, 0);
        tick();
        tick();
        check("init_write_total", 64'(wr_total - wr_start), 16);
        check("d0_no_init_writes", 64'(wr0_total), 0);

        // Basic write then read, plus a partial byte-enable write.
        do_write(4'd5, 64'hDEADBEEF_CAFEF00D, 8'hFF);
        do_read(4'd5);
        check("rd5_literal", rsp_rdata, 64'hDEADBEEF_CAFEF00D);
        do_write(4'd6, 64'h1111_1111_1111_1111, 8'h0F);
        do_read(4'd6);
        check("be_merge", rsp_rdata, 64'h0000_0000_1111_1111);

        do_write(4'd1, 64'hAAAA_0001_AAAA_0001, 8'hFF);
        do_write(4'd2, 64'hBBBB_0002_BBBB_0002, 8'hFF);
        do_write(4'd3, 64'hCCCC_0003_CCCC_0003, 8'hFF);

        // Back-to-back reads under backpressure.
        rsp_ready = 1'b0;
        drive(1, 0, 4'd1, 0, 0);
        check("bp_ready_a1", req_ready, 1);
        tick();
        drive(1, 0, 4'd2, 0, 0);
        check("bp_ready_a2", req_ready, 1);
        check("bp_rsp_a2", rsp_rdata, 64'hAAAA_0001_AAAA_0001);
        tick();
        drive(1, 0, 4'd3, 0, 0);
        check("bp_ready_a3", req_ready, 0);
        check("bp_sram_req_a3", sram_req, 0);
        check("bp_rsp_valid", rsp_valid, 1);
        check("bp_rsp_hold1", rsp_rdata, 64'hAAAA_0001_AAAA_0001);
        tick();
        check("bp_ready_hold", req_ready, 0);
        check("bp_rsp_hold2", rsp_rdata, 64'hAAAA_0001_AAAA_0001);
        rsp_ready = 1'b1;
        #1;
        check("bp_ready_full", req_ready, 0);
        check("bp_rsp_1", rsp_rdata, 64'hAAAA_0001_AAAA_0001);
        tick();
        check("bp_ready_a3_ok", req_ready, 1);
        check("bp_rsp_2", rsp_rdata, 64'hBBBB_0002_BBBB_0002);
        tick();
        drive(0, 0, 0, 0, 0);
        check("bp_rsp_3_valid", rsp_valid, 1);
        check("bp_rsp_3", rsp_rdata, 64'hCCCC_0003_CCCC_0003);
        tick();
        check("bp_drained", rsp_valid, 0);

        // Streaming reads, one per cycle.
        for (int k = 0; k < 10; k++)
            do_write(4'(k), 64'hC0DE_0000_5A5A_0000 + (64'(k) << 32) + 64'(k * 7), 8'hFF);
        for (int k = 0; k <= 10; k++) begin
            if (k < 10) drive(1, 0, 4'(k), 0, 0);
            else        drive(0, 0, 0, 0, 0);
            if (k < 10) check("stream_ready", req_ready, 1);
            if (k > 0) begin
                check("stream_rsp_valid", rsp_valid, 1);
                check("stream_rsp_rdata", rsp_rdata, exp_mem[k-1]);
            end
            tick();
        end
        check("stream_drained", rsp_valid, 0);

        // Reset mid-RUN, then again mid-INIT at address 7.
        rst = 1'b1;
        #1;
        check("rrun_sram_req", sram_req, 0);
        check("rrun_init_done", init_done, 0);
        tick();
        rst = 1'b0;
        #1;
        run_init(7, 0);
        rst = 1'b1;
        #1;
        check("rinit_sram_req", sram_req, 0);
        check("rinit_sram_we", sram_we, 0);
        check("rinit_sram_addr", sram_addr, 0);
        check("rinit_sram_be", sram_be, 0);
        check("rinit_init_done", init_done, 0);
        tick();
        rst = 1'b0;
        #1;
        run_init(16, 0);

        // Reset with two responses held in the FIFO.
        do_write(4'd1, 64'h7777_7777_0000_0001, 8'hFF);
        do_write(4'd2, 64'h8888_8888_0000_0002, 8'hFF);
        rsp_ready = 1'b0;
        drive(1, 0, 4'd1, 0, 0);
        tick();
        drive(1, 0, 4'd2, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        tick();
        check("full_rsp_valid", rsp_valid, 1);
        check("full_rsp_rdata", rsp_rdata, 64'h7777_7777_0000_0001);
        check("full_ready", req_ready, 0);
        rst = 1'b1;
        #1;
        check("rfifo_rsp_valid", rsp_valid, 0);
        check("rfifo_rsp_rdata", rsp_rdata, 0);
        check("rfifo_ready", req_ready, 0);
        tick();
        rst = 1'b0;
        rsp_ready = 1'b1;
        #1;
        run_init(16, 0);
        check("no_stale_rsp", rsp_valid, 0);
        do_read(4'd1);
        check("reinit_zero", rsp_rdata, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
